// File: rtl/semaforo_seq.sv
// semaforo_seq: N-phase demand-driven traffic-light sequencer with its own ms prescaler.
// Build option: define SEMAFORO_SEQ_FLASH_EN to flash all yellows while en is low.
// Default build: en low freezes prescaler, timer, FSM and outputs.

module semaforo_seq #(
  parameter int unsigned N_PHASES  = 3,
  parameter int unsigned TICK_DIV  = 10,
  parameter int unsigned TW        = 18,
  parameter int unsigned GREEN_MS  = 20000,
  parameter int unsigned YELLOW_MS = 3000,
  parameter int unsigned ALLRED_MS = 1000,
  parameter int unsigned PED_MS    = 8000,
  parameter int unsigned PW        = $clog2(N_PHASES)
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                en,
  input  logic [N_PHASES-1:0] sensor,
  input  logic [N_PHASES-1:0] ped_req,
  output logic [N_PHASES-1:0] green,
  output logic [N_PHASES-1:0] yellow,
  output logic [N_PHASES-1:0] red,
  output logic [N_PHASES-1:0] ped_green,
  output logic [N_PHASES-1:0] ped_red,
  output logic [PW-1:0]       phase,
  output logic [1:0]          state
);

  localparam int unsigned   CW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] PRESC_LAST  = CW'(TICK_DIV - 1);
  localparam logic [TW-1:0] ALLRED_LAST = TW'(ALLRED_MS - 1);
  localparam logic [TW-1:0] GREEN_LAST  = TW'(GREEN_MS - 1);
  localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_MS - 1);
  localparam logic [TW-1:0] PED_LIMIT   = TW'(PED_MS);
  localparam logic [PW-1:0] PH_LAST     = PW'(N_PHASES - 1);

`ifdef SEMAFORO_SEQ_FLASH_EN
  localparam int unsigned   FW          = 9;
  localparam logic [FW-1:0] FLASH_LAST  = FW'(499);
`endif

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2
  } st_e;

  // state registers
  logic [CW-1:0]       presc_q, presc_d;
  logic [TW-1:0]       timer_q, timer_d;
  st_e                 st_q, st_d;
  logic [PW-1:0]       ph_q, ph_d;
  logic [N_PHASES-1:0] latch_q, latch_d;
  logic                walk_q, walk_d;

  // registered outputs, next values
  logic [N_PHASES-1:0] green_q, yellow_q, red_q, ped_green_q, ped_red_q;
  logic [N_PHASES-1:0] green_d, yellow_d, red_d, ped_green_d, ped_red_d;

  // combinational helpers
  logic                tick_c;
  logic [TW-1:0]       last_c;
  logic [N_PHASES-1:0] demand_c;
  logic [PW-1:0]       sel_c;
  logic [PW-1:0]       cand_c;
  logic                found_c;

`ifdef SEMAFORO_SEQ_FLASH_EN
  logic [FW-1:0]       flash_cnt_q, flash_cnt_d;
  logic                flash_on_q, flash_on_d;
`endif

  // Next phase: first demanding index after the current one, wrapping, else plain rotation.
  always_comb begin
    demand_c = sensor | latch_q;
    sel_c    = (ph_q == PH_LAST) ? '0 : ph_q + PW'(1);
    found_c  = 1'b0;
    cand_c   = '0;
    for (int unsigned k = 1; k <= N_PHASES; k++) begin
      cand_c = PW'((32'(ph_q) + k) % N_PHASES);
      if (!found_c && demand_c[cand_c]) begin
        sel_c   = cand_c;
        found_c = 1'b1;
      end
    end
  end

  // Next-state, timer, ped latches and next output values.
  always_comb begin
    presc_d     = presc_q;
    timer_d     = timer_q;
    st_d        = st_q;
    ph_d        = ph_q;
    latch_d     = latch_q | ped_req;
    walk_d      = walk_q;
    green_d     = '0;
    yellow_d    = '0;
    red_d       = '1;
    ped_green_d = '0;
    ped_red_d   = '1;
    tick_c      = (presc_q == PRESC_LAST);
`ifdef SEMAFORO_SEQ_FLASH_EN
    flash_cnt_d = flash_cnt_q;
    flash_on_d  = flash_on_q;
`endif

    case (st_q)
      ST_GREEN:  last_c = GREEN_LAST;
      ST_YELLOW: last_c = YELLOW_LAST;
      default:   last_c = ALLRED_LAST;
    endcase

    if (en) begin
      presc_d = tick_c ? '0 : presc_q + CW'(1);
      if (tick_c) begin
        if (timer_q == last_c) begin
          timer_d = '0;
          case (st_q)
            ST_ALL_RED: begin
              st_d           = ST_GREEN;
              ph_d           = sel_c;
              // a press coinciding with service is consumed by this walk
              latch_d[sel_c] = 1'b0;
              walk_d         = latch_q[sel_c] | ped_req[sel_c];
            end
            ST_GREEN: st_d = ST_YELLOW;
            default:  st_d = ST_ALL_RED;
          endcase
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
    end

    // lights follow the state register by one cycle
    for (int unsigned i = 0; i < N_PHASES; i++) begin
      if (ph_q == PW'(i)) begin
        green_d[i]     = (st_q == ST_GREEN);
        yellow_d[i]    = (st_q == ST_YELLOW);
        red_d[i]       = !((st_q == ST_GREEN) || (st_q == ST_YELLOW));
        ped_green_d[i] = (st_q == ST_GREEN) && walk_q && (timer_q < PED_LIMIT);
        ped_red_d[i]   = !ped_green_d[i];
      end
    end

`ifdef SEMAFORO_SEQ_FLASH_EN
    if (en) begin
      flash_cnt_d = '0;
      flash_on_d  = 1'b1;
    end else begin
      // prescaler keeps running to pace the flash; FSM and timer stay parked
      presc_d = tick_c ? '0 : presc_q + CW'(1);
      if (tick_c) begin
        if (flash_cnt_q == FLASH_LAST) begin
          flash_cnt_d = '0;
          flash_on_d  = !flash_on_q;
        end else begin
          flash_cnt_d = flash_cnt_q + FW'(1);
        end
      end
      green_d     = '0;
      yellow_d    = {N_PHASES{flash_on_q}};
      red_d       = '0;
      ped_green_d = '0;
      ped_red_d   = '1;
    end
`endif
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      presc_q     <= '0;
      timer_q     <= '0;
      st_q        <= ST_ALL_RED;
      ph_q        <= PH_LAST;
      latch_q     <= '0;
      walk_q      <= 1'b0;
      green_q     <= '0;
      yellow_q    <= '0;
      red_q       <= '1;
      ped_green_q <= '0;
      ped_red_q   <= '1;
`ifdef SEMAFORO_SEQ_FLASH_EN
      flash_cnt_q <= '0;
      flash_on_q  <= 1'b1;
`endif
    end else begin
      presc_q     <= presc_d;
      timer_q     <= timer_d;
      st_q        <= st_d;
      ph_q        <= ph_d;
      latch_q     <= latch_d;
      walk_q      <= walk_d;
      green_q     <= green_d;
      yellow_q    <= yellow_d;
      red_q       <= red_d;
      ped_green_q <= ped_green_d;
      ped_red_q   <= ped_red_d;
`ifdef SEMAFORO_SEQ_FLASH_EN
      flash_cnt_q <= flash_cnt_d;
      flash_on_q  <= flash_on_d;
`endif
    end
  end

  assign green     = green_q;
  assign yellow    = yellow_q;
  assign red       = red_q;
  assign ped_green = ped_green_q;
  assign ped_red   = ped_red_q;
  assign phase     = ph_q;
  assign state     = st_q;

endmodule

// File: tb/tb_semaforo_seq.sv
// tb_semaforo_seq: scoreboard bench for semaforo_seq with a cycle-counting reference model.

module tb_semaforo_seq;

  localparam int N   = 3;
  localparam int TD  = 2;
  localparam int GMS = 4;
  localparam int YMS = 2;
  localparam int AMS = 1;
  localparam int PMS = 2;

  logic       CLK;
  logic       reset;
  logic       en;
  logic [2:0] sensor;
  logic [2:0] ped_req;
  logic [2:0] green, yellow, red, ped_green, ped_red;
  logic [1:0] phase;
  logic [1:0] state;

  semaforo_seq #(
    .N_PHASES(3), .TICK_DIV(2), .TW(18), .GREEN_MS(4), .YELLOW_MS(2),
    .ALLRED_MS(1), .PED_MS(2)
  ) dut (
    .CLK(CLK), .reset(reset), .en(en), .sensor(sensor), .ped_req(ped_req),
    .green(green), .yellow(yellow), .red(red), .ped_green(ped_green),
    .ped_red(ped_red), .phase(phase), .state(state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] g;
    logic [2:0] y;
    logic [2:0] r;
    logic [2:0] pg;
    logic [2:0] pr;
    logic [1:0] ph;
    logic [1:0] st;
  } obs_t;

  obs_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: state kind, phase, enabled cycles spent in state, pending presses.
  int         m_state;   // 0 all-red, 1 green, 2 yellow
  int         m_phase;
  int         m_elapsed;
  logic [2:0] m_pend;
  bit         m_walk;
  logic [2:0] sens;

  function automatic int dur_cycles(input int s);
    if (s == 1) return GMS * TD;
    if (s == 2) return YMS * TD;
    return AMS * TD;
  endfunction

  function automatic int pick(input int cur, input logic [2:0] demand);
    for (int k = 1; k <= N; k++) begin
      if (demand[(cur + k) % N]) return (cur + k) % N;
    end
    return (cur + 1) % N;
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic [2:0] s, input logic [2:0] p);
    obs_t       x;
    logic [2:0] old_pend;
    x = '0;
    if (!r) begin
      m_state = 0; m_phase = N - 1; m_elapsed = 0; m_pend = '0; m_walk = 0;
      x.r = 3'b111; x.pr = 3'b111;
    end else begin
      for (int i = 0; i < N; i++) begin
        x.g[i]  = (m_state == 1) && (m_phase == i);
        x.y[i]  = (m_state == 2) && (m_phase == i);
        x.r[i]  = !(x.g[i] || x.y[i]);
        x.pg[i] = x.g[i] && m_walk && (m_elapsed < PMS * TD);
        x.pr[i] = !x.pg[i];
      end
      old_pend = m_pend;
      m_pend   = m_pend | p;
      if (e) begin
        m_elapsed++;
        if (m_elapsed == dur_cycles(m_state)) begin
          m_elapsed = 0;
          if (m_state == 0) begin
            m_phase         = pick(m_phase, s | old_pend);
            m_state         = 1;
            m_pend[m_phase] = 1'b0;
            m_walk          = old_pend[m_phase] | p[m_phase];
          end else if (m_state == 1) begin
            m_state = 2;
          end else begin
            m_state = 0;
          end
        end
      end
    end
    x.ph = 2'(m_phase);
    x.st = 2'(m_state);
    sb_q.push_back(x);
  endtask

  // Drive one cycle of inputs, record the expectation, return once outputs settle.
  task automatic step(input logic r, input logic e, input logic [2:0] s, input logic [2:0] p);
    @(negedge CLK);
    reset = r; en = e; sensor = s; ped_req = p;
    model_edge(r, e, s, p);
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] outsel(input int k);
    case (k)
      0:       return green;
      1:       return yellow;
      2:       return red;
      default: return ped_green;
    endcase
  endfunction

  task automatic count_run(input int k, input logic [2:0] v, output int n);
    n = 0;
    while (outsel(k) == v && n < 100) begin
      n++;
      step(1'b1, 1'b1, sens, 3'b000);
    end
  endtask

  task automatic wait_green(input string nm, input int budget);
    int i;
    i = 0;
    while (green == 3'b000 && i < budget) begin
      i++;
      step(1'b1, 1'b1, sens, 3'b000);
    end
    if (green == 3'b000) chk({nm, "_timeout"}, i, -1);
  endtask

  task automatic do_reset();
    repeat (3) step(1'b0, 1'b1, sens, 3'b000);
  endtask

  // Monitor: every settled edge pops one expectation and compares the full output set.
  obs_t exp_o, act_o;
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (sb_q.size() != 0) begin
        exp_o = sb_q.pop_front();
        act_o = {green, yellow, red, ped_green, ped_red, phase, state};
        total++;
        if (act_o !== exp_o) begin
          bad++;
          $display("FAIL scoreboard @%0t: got g=%b y=%b r=%b pg=%b pr=%b ph=%0d st=%0d want g=%b y=%b r=%b pg=%b pr=%b ph=%0d st=%0d",
                   $time, act_o.g, act_o.y, act_o.r, act_o.pg, act_o.pr, act_o.ph, act_o.st,
                   exp_o.g, exp_o.y, exp_o.r, exp_o.pg, exp_o.pr, exp_o.ph, exp_o.st);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    int         n, c1, c2, diffs;
    logic [1:0] snap_ph, snap_st;
    logic [14:0] snap;
    reset = 1'b0; en = 1'b1; sensor = '0; ped_req = '0; sens = '0;
    m_state = 0; m_phase = N - 1; m_elapsed = 0; m_pend = '0; m_walk = 0;

    // reset values and plain rotation with no demand
    do_reset();
    chk("rst_red",   int'(red),   7);
    chk("rst_green", int'(green), 0);
    chk("rst_phase", int'(phase), 2);
    chk("rst_state", int'(state), 0);
    wait_green("rot_first", 20);
    chk("rot_first_green", int'(green), 1);
    count_run(0, 3'b001, n);  chk("rot_green_len", n, 8);
    count_run(1, 3'b001, n);  chk("rot_yellow_len", n, 4);
    count_run(2, 3'b111, n);  chk("rot_allred_len", n, 2);
    chk("rot_second_green", int'(green), 2);

    // demand skip: only sensor[2]
    sens = 3'b100;
    do_reset();
    wait_green("skip_first", 20);
    chk("skip_first_green", int'(green), 4);
    count_run(0, 3'b100, n);
    wait_green("skip_second", 40);
    chk("skip_second_green", int'(green), 4);

    // pedestrian request during phase 0 green, then press during own green
    sens = 3'b000;
    do_reset();
    wait_green("ped_first", 20);
    step(1'b1, 1'b1, sens, 3'b010);
    n = 0;
    while (green != 3'b010 && n < 40) begin
      n++;
      step(1'b1, 1'b1, sens, 3'b000);
    end
    chk("ped_served_green", int'(green), 2);
    count_run(3, 3'b010, n);  chk("ped_walk_len", n, 4);
    chk("ped_red_after_walk", int'(ped_red), 7);
    step(1'b1, 1'b1, sens, 3'b010);
    count_run(0, 3'b010, n);  chk("ped_green_tail", 1 + n, 4);
    wait_green("ped_again", 40);
    chk("ped_again_green", int'(green), 2);
    chk("ped_again_walk", int'(ped_green), 2);

    // enable hold mid-green
    do_reset();
    wait_green("hold_first", 20);
    c1 = 1;
    repeat (2) begin
      step(1'b1, 1'b1, sens, 3'b000);
      if (green == 3'b001) c1++;
    end
    snap = {green, yellow, red, ped_green, ped_red};
    snap_ph = phase; snap_st = state;
    diffs = 0;
    repeat (20) begin
      step(1'b1, 1'b0, sens, 3'b000);
      if ({green, yellow, red, ped_green, ped_red} != snap || phase != snap_ph || state != snap_st) diffs++;
    end
    chk("hold_frozen", diffs, 0);
    step(1'b1, 1'b1, sens, 3'b000);
    count_run(0, 3'b001, c2);
    chk("hold_green_total", c1 + c2, 8);

    // reset in yellow drops a pending press on phase 2
    step(1'b1, 1'b1, sens, 3'b100);
    step(1'b0, 1'b1, sens, 3'b000);
    chk("midrst_red",   int'(red),   7);
    chk("midrst_phase", int'(phase), 2);
    chk("midrst_state", int'(state), 0);
    wait_green("midrst_next", 20);
    chk("midrst_next_green", int'(green), 1);

    // randomized traffic, checked by the scoreboard
    for (int i = 0; i < 1500; i++) begin
      logic       r, e;
      logic [2:0] s, p;
      r = ($urandom_range(0, 299) != 0);
      e = ($urandom_range(0, 9) != 0);
      for (int b = 0; b < 3; b++) begin
        s[b] = ($urandom_range(0, 3) == 0);
        p[b] = ($urandom_range(0, 15) == 0);
      end
      step(r, e, s, p);
    end

    repeat (2) @(negedge CLK);
    chk("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/semaforo_seq.md
Name: semaforo_seq

Overview:
- Parametrised N-phase traffic-light sequencer. It is the successor to the single fixed semaforo/semaforo2 lights.
- Drives green/yellow/red for N vehicle phases plus one walk/don't-walk pair per phase.
- Phases are served in demand-driven rotation: vehicle sensors and latched pedestrian buttons decide which phase comes next.
- Contains its own ms prescaler, so it runs directly from CLK_10k. No external chronometer is needed.

Parameters:
- N_PHASES, 3, number of vehicle phases (2..8).
- TICK_DIV, 10, CLK cycles per ms tick.
- TW, 18, width of the ms timer.
- GREEN_MS, 20000, green duration per phase.
- YELLOW_MS, 3000, yellow duration.
- ALLRED_MS, 1000, all-red clearance between phases.
- PED_MS, 8000, walk duration. Must be <= GREEN_MS.
- PW, $clog2(N_PHASES), width of the phase index.

Ports:
- CLK, in, 1, sole clock (10 kHz).
- reset, in, 1, synchronous, active-low. reset==0 at a CLK rising edge resets the block.
- en, in, 1, run enable.
- sensor, in, N_PHASES, vehicle present per phase (level).
- ped_req, in, N_PHASES, pedestrian button per phase (level, any width).
- green, out, N_PHASES, vehicle green.
- yellow, out, N_PHASES, vehicle yellow.
- red, out, N_PHASES, vehicle red.
- ped_green, out, N_PHASES, walk.
- ped_red, out, N_PHASES, don't walk.
- phase, out, PW, currently selected phase index.
- state, out, 2, 0=ALL_RED, 1=GREEN, 2=YELLOW.

Behaviour:
- Reset (reset==0 on a posedge):
  - state=ALL_RED, phase=N_PHASES-1, prescaler=0, timer=0, ped latches=0.
  - red=all 1, green=0, yellow=0, ped_red=all 1, ped_green=0.
- Prescaler counts 0..TICK_DIV-1. tick is high for one cycle when the count equals TICK_DIV-1, and the count then wraps to 0.
- en==0: prescaler, timer, state and phase all hold; outputs hold. Ped latching continues.
- Timer counts ticks spent in the current state. On a tick with timer==DUR-1, the FSM moves to the next state and the timer goes to 0. Every state therefore lasts exactly DUR*TICK_DIV CLK cycles.
- FSM transitions:
  - ALL_RED(ALLRED_MS) -> GREEN.
  - GREEN(GREEN_MS) -> YELLOW.
  - YELLOW(YELLOW_MS) -> ALL_RED.
- Phase selection happens on the ALL_RED->GREEN transition:
  - Search indices phase+1, phase+2, ... wrapping modulo N_PHASES, ending with phase itself.
  - The first index whose sensor or ped latch is 1 becomes the new phase.
  - If no phase has demand, the new phase is (phase+1) mod N_PHASES (plain rotation).
- Vehicle outputs are registered, one-hot on the selected phase:
  - GREEN state: green[phase]=1, red[phase]=0.
  - YELLOW state: yellow[phase]=1, red[phase]=0.
  - All other phases, and every phase in ALL_RED: red=1.
  - For every i, exactly one of green/yellow/red[i] is set.
- Ped latch[i]:
  - Set on any cycle with ped_req[i]=1.
  - Cleared in the cycle phase i enters GREEN, and that service is recorded in walk_flag.
  - If set and clear coincide in the same cycle, the clear wins and walk_flag=1.
  - A press during phase i's own GREEN/YELLOW re-latches for the next service.
- Walk: ped_green[i]=1 and ped_red[i]=0 while state==GREEN, phase==i, walk_flag==1 and timer<PED_MS. Otherwise ped_green=0 and ped_red=1.
- Timing reference: green appears in the cycle after the transitioning tick. Outputs have one cycle of latency from the state register.
- Reset mid-phase immediately forces the reset values on the next edge. Latched requests are lost.

Optional Feature:
- Macro: SEMAFORO_SEQ_FLASH_EN.
- Defined: while en==0, the prescaler and a 500 ms flash counter keep running.
  - yellow = all phases toggling every 500 ticks, starting at 1.
  - green=0, red=0, ped outputs=don't-walk.
  - The FSM, timer and phase hold.
  - On en rising, the FSM resumes in its held state with the timer unchanged; the flash counter resets to 0.
- Not defined: en==0 freezes everything, as described in Behaviour.

Test Plan:
- Test-plan parameters: N_PHASES=3, TICK_DIV=2, GREEN_MS=4, YELLOW_MS=2, ALLRED_MS=1, PED_MS=2. Apply reset=0 for 3 cycles, then release.
- Reset check: red=3'b111, green=0, phase=2, state=0. With no demand: after 2 cycles green=3'b001 for 8 cycles, then yellow=3'b001 for 4 cycles, then all-red for 2 cycles, then green=3'b010.
- Demand skip: sensor=3'b100 held from reset -> first green=3'b100 (phase 2); the next service is phase 2 again while only sensor[2]=1.
- Ped request: pulse ped_req[1] for 1 cycle during phase 0 green -> phase 1 is served next. ped_green=3'b010 for the first 4 cycles of that green, then ped_red[1]=1 while green[1] remains high for 4 more cycles.
- Ped press during own walk: ped_req[1] high during phase 1 green -> latch stays 1 after the green, and phase 1 is served again on rotation with walk.
- Enable hold: en=0 for 20 cycles mid-GREEN -> outputs and state unchanged. After en=1, the remaining green time equals the pre-freeze remainder exactly. With SEMAFORO_SEQ_FLASH_EN, and TICK_DIV=2 for this test, yellow=3'b111 toggles every 1000 cycles.
- Mid-yellow reset: reset=0 for 1 cycle -> the next edge gives red=3'b111, ped latches cleared, phase=2.
